// File: rtl/sr_latch_bank.sv
// sr_latch_bank: bank of CH clocked set/reset cells with per-channel input
// debounce, selectable S=R=1 resolution (MODE) and sticky invalid flags.
// Optional feature macro: SR_BANK_ERRCNT_EN adds a saturating counter of
// invalid-event cycles on err_cnt; without it err_cnt is tied to zero.
module sr_latch_bank #(
  parameter int CH    = 8,
  parameter int MODE  = 0,
  parameter int FILT  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    s,
  input  logic [CH-1:0]    r,
  input  logic             en,
  input  logic             err_clr,
  output logic [CH-1:0]    q,
  output logic [CH-1:0]    qn,
  output logic [CH-1:0]    err,
  output logic             err_any,
  output logic [CNT_W-1:0] err_cnt
);

  // FILT and MODE folded to the widths the datapath compares against
  localparam logic [3:0] FILT_L  = 4'(FILT);
  localparam logic [1:0] MODE_L  = 2'(MODE);
  localparam logic [3:0] RUN_MAX = 4'hF;

  logic [CH-1:0][1:0] r_hist;
  logic [CH-1:0][3:0] r_run;
  logic [CH-1:0]      r_q;
  logic [CH-1:0]      r_qn;
  logic [CH-1:0]      r_err;

  logic [CH-1:0][1:0] w_pair;
  logic [CH-1:0][3:0] w_run_nxt;
  logic [CH-1:0]      w_qual;
  logic [CH-1:0]      w_q_nxt;
  logic [CH-1:0]      w_err_set;
  logic [CH-1:0]      w_err_nxt;

  // Filter run tracking, qualification and next-state resolution per channel
  always_comb begin
    w_pair    = '0;
    w_run_nxt = '0;
    w_qual    = '0;
    w_q_nxt   = r_q;
    w_err_set = '0;
    for (int i = 0; i < CH; i++) begin
      w_pair[i] = {s[i], r[i]};
      // run counts how many earlier edges sampled this same pair
      if (w_pair[i] == r_hist[i]) begin
        if (r_run[i] == RUN_MAX) begin
          w_run_nxt[i] = RUN_MAX;
        end else begin
          w_run_nxt[i] = r_run[i] + 4'd1;
        end
      end else begin
        w_run_nxt[i] = 4'd0;
      end
      // qualified once the pair has been seen on FILT+1 consecutive edges
      w_qual[i] = (({1'b0, w_run_nxt[i]} + 5'd1) > {1'b0, FILT_L});
      if (en && w_qual[i]) begin
        case (w_pair[i])
          2'b10: w_q_nxt[i] = 1'b1;
          2'b01: w_q_nxt[i] = 1'b0;
          2'b11: begin
            w_err_set[i] = 1'b1;
            case (MODE_L)
              2'd0:    w_q_nxt[i] = 1'b1;
              2'd1:    w_q_nxt[i] = 1'b0;
              2'd2:    w_q_nxt[i] = r_q[i];
              2'd3:    w_q_nxt[i] = ~r_q[i];
              default: w_q_nxt[i] = r_q[i];
            endcase
          end
          default: w_q_nxt[i] = r_q[i];
        endcase
      end else begin
        w_q_nxt[i] = r_q[i];
      end
    end
  end

  // Sticky flags: a clear drops all bits, but a same-edge set survives it
  always_comb begin
    w_err_nxt = '0;
    if (err_clr) begin
      w_err_nxt = w_err_set;
    end else begin
      w_err_nxt = r_err | w_err_set;
    end
  end

  // Filter history, channel state (q and qn together) and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_run  <= '0;
      r_q    <= '0;
      r_qn   <= '1;
      r_err  <= '0;
    end else begin
      r_hist <= w_pair;
      r_run  <= w_run_nxt;
      r_q    <= w_q_nxt;
      r_qn   <= ~w_q_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign q       = r_q;
  assign qn      = r_qn;
  assign err     = r_err;
  assign err_any = |r_err;

`ifdef SR_BANK_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;
  logic             w_evt;

  assign w_evt = |w_err_set;

  // Saturating count of edges on which any channel raised its flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (err_clr) begin
      r_cnt <= w_evt ? CNT_W'(1'b1) : '0;
    end else if (w_evt && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1'b1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign err_cnt = r_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_latch_bank.sv
// Testbench for sr_latch_bank: one FILT=2 / MODE0 bank plus four FILT=0 banks
// (MODE 0..3) share the stimulus. A window-based reference model predicts all
// outputs and is compared every falling edge; directed literals pin the model.
module tb_sr_latch_bank;

  localparam int NI = 5;
  localparam int P_CH   [NI] = '{8, 4, 4, 4, 4};
  localparam int P_MODE [NI] = '{0, 0, 1, 2, 3};
  localparam int P_FILT [NI] = '{2, 0, 0, 0, 0};
  localparam int P_CMAX [NI] = '{3, 255, 255, 255, 255};

  logic       clk;
  logic       rst_n;
  logic [7:0] s;
  logic [7:0] r;
  logic       en;
  logic       err_clr;

  logic [7:0] main_q, main_qn, main_err;
  logic       main_any;
  logic [1:0] main_cnt;
  logic [3:0] md_q   [4];
  logic [3:0] md_qn  [4];
  logic [3:0] md_err [4];
  logic       md_any [4];
  logic [7:0] md_cnt [4];

  int n_checks;
  int n_fail;

  // reference model state
  logic [1:0] win  [NI][8][16];
  int         nval [NI][8];
  logic       mq   [NI][8];
  logic       merr [NI][8];
  int         mcnt [NI];

  sr_latch_bank #(.CH(8), .MODE(0), .FILT(2), .CNT_W(2)) u_main (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .err_clr(err_clr),
    .q(main_q), .qn(main_qn), .err(main_err), .err_any(main_any), .err_cnt(main_cnt)
  );

  for (genvar g = 0; g < 4; g++) begin : g_md
    sr_latch_bank #(.CH(4), .MODE(g), .FILT(0), .CNT_W(8)) u_md (
      .clk(clk), .rst_n(rst_n), .s(s[3:0]), .r(r[3:0]), .en(en), .err_clr(err_clr),
      .q(md_q[g]), .qn(md_qn[g]), .err(md_err[g]), .err_any(md_any[g]), .err_cnt(md_cnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int u = 0; u < NI; u++) begin
      mcnt[u] = 0;
      for (int c = 0; c < 8; c++) begin
        nval[u][c] = 0;
        mq[u][c]   = 1'b0;
        merr[u][c] = 1'b0;
        for (int k = 0; k < 16; k++) win[u][c][k] = 2'b00;
      end
    end
  endtask

  // one clock edge of the reference: a pair acts only if the last FILT+1
  // samples since reset are all identical to it
  task automatic model_step();
    for (int u = 0; u < NI; u++) begin
      bit any_set;
      any_set = 1'b0;
      if (err_clr) for (int c = 0; c < 8; c++) merr[u][c] = 1'b0;
      for (int c = 0; c < P_CH[u]; c++) begin
        logic [1:0] p;
        bit qual;
        p = {s[c], r[c]};
        for (int k = 15; k > 0; k--) win[u][c][k] = win[u][c][k-1];
        win[u][c][0] = p;
        if (nval[u][c] < 16) nval[u][c]++;
        qual = (nval[u][c] >= P_FILT[u] + 1);
        for (int k = 0; k <= P_FILT[u]; k++) if (win[u][c][k] != p) qual = 1'b0;
        if (en && qual) begin
          if (p == 2'b10) mq[u][c] = 1'b1;
          else if (p == 2'b01) mq[u][c] = 1'b0;
          else if (p == 2'b11) begin
            merr[u][c] = 1'b1;
            any_set = 1'b1;
            if (P_MODE[u] == 0) mq[u][c] = 1'b1;
            else if (P_MODE[u] == 1) mq[u][c] = 1'b0;
            else if (P_MODE[u] == 3) mq[u][c] = ~mq[u][c];
          end
        end
      end
      if (err_clr) mcnt[u] = any_set ? 1 : 0;
      else if (any_set && mcnt[u] < P_CMAX[u]) mcnt[u]++;
    end
  endtask

  // reference model follows the DUT clock and its asynchronous reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  task automatic check(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d actual=%0h required=%0h t=%0t", nm, u, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int u = 0; u < NI; u++) begin
      logic [7:0] eq, eerr, mask, aq, aqn, aerr;
      logic       aany;
      int         acnt, ecnt;
      eq = '0; eerr = '0;
      for (int c = 0; c < P_CH[u]; c++) begin
        eq[c]   = mq[u][c];
        eerr[c] = merr[u][c];
      end
      mask = (u == 0) ? 8'hFF : 8'h0F;
      if (u == 0) begin
        aq = main_q; aqn = main_qn; aerr = main_err; aany = main_any; acnt = int'(main_cnt);
      end else begin
        aq = {4'h0, md_q[u-1]}; aqn = {4'h0, md_qn[u-1]}; aerr = {4'h0, md_err[u-1]};
        aany = md_any[u-1]; acnt = int'(md_cnt[u-1]);
      end
`ifdef SR_BANK_ERRCNT_EN
      ecnt = mcnt[u];
`else
      ecnt = 0;
`endif
      check("q", u, 32'(aq), 32'(eq));
      check("qn", u, 32'(aqn), 32'((~eq) & mask));
      check("err", u, 32'(aerr), 32'(eerr));
      check("err_any", u, 32'(aany), 32'(|eerr));
      check("err_cnt", u, 32'(acnt), 32'(ecnt));
    end
  endtask

  // n edges, comparing after each; returns just after a falling edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_all();
    end
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b1; s = 8'hFF; r = 8'hFF; en = 1'b1; err_clr = 1'b0;
    #1 rst_n = 1'b0;
    cyc(2);
    check("lit_rst_q", 0, 32'(main_q), 32'h00);
    check("lit_rst_qn", 0, 32'(main_qn), 32'hFF);
    check("lit_rst_err", 0, 32'(main_err), 32'h00);
    s = 8'h00; r = 8'h00;
    cyc(1);
    rst_n = 1'b1;

    // basic set then reset on ch0 (FILT=2 acts on 3rd edge)
    s = 8'h01;
    cyc(2);
    check("lit_set_early", 0, 32'(main_q[0]), 32'h0);
    check("lit_set_f0", 1, 32'(md_q[0][0]), 32'h1);
    cyc(1);
    check("lit_set_edge3", 0, 32'(main_q[0]), 32'h1);
    s = 8'h00; r = 8'h01;
    cyc(2);
    check("lit_rst_early", 0, 32'(main_q[0]), 32'h1);
    cyc(1);
    check("lit_rst_edge3", 0, 32'(main_q[0]), 32'h0);

    // glitch rejection on ch3
    r = 8'h00; s = 8'h08;
    cyc(2);
    s = 8'h00;
    cyc(2);
    check("lit_glitch_q", 0, 32'(main_q[3]), 32'h0);
    check("lit_glitch_err", 0, 32'(main_err), 32'h00);
    s = 8'h08;
    cyc(3);
    check("lit_held_q3", 0, 32'(main_q[3]), 32'h1);

    // MODE sweep with s=r=1 held on ch0
    s = 8'h01; r = 8'h01;
    cyc(1);
    check("lit_m0", 1, 32'(md_q[0][0]), 32'h1);
    check("lit_m1", 2, 32'(md_q[1][0]), 32'h0);
    check("lit_m2", 3, 32'(md_q[2][0]), 32'h0);
    check("lit_m3_e1", 4, 32'(md_q[3][0]), 32'h1);
    for (int g = 0; g < 4; g++) check("lit_m_err", g + 1, 32'(md_err[g][0]), 32'h1);
    cyc(1);
    check("lit_m3_e2", 4, 32'(md_q[3][0]), 32'h0);
    cyc(1);
    check("lit_m3_e3", 4, 32'(md_q[3][0]), 32'h1);
    check("lit_main_11", 0, 32'(main_q[0]), 32'h1);
    cyc(1);
    check("lit_m3_e4", 4, 32'(md_q[3][0]), 32'h0);

    // err_clr together with a qualified 11 on ch1
    s = 8'h04; r = 8'h04;
    cyc(3);
    check("lit_err_pre", 0, 32'(main_err), 32'h05);
    s = 8'h02; r = 8'h02;
    cyc(2);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("lit_clr_set", 0, 32'(main_err), 32'h02);
    check("lit_clr_any", 0, 32'(main_any), 32'h1);
    check("lit_clr_md", 1, 32'(md_err[0]), 32'h2);
    s = 8'h00; r = 8'h00; err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("lit_clr_all", 0, 32'(main_err), 32'h00);
    check("lit_clr_any0", 0, 32'(main_any), 32'h0);
    check("lit_clr_cnt", 0, 32'(main_cnt), 32'h0);

    // en gating: qualified 10 on ch4 and 11 on ch5 while disabled
    en = 1'b0; s = 8'h30; r = 8'h20;
    cyc(4);
    check("lit_en0_q", 0, 32'(main_q[4]), 32'h0);
    check("lit_en0_err", 0, 32'(main_err), 32'h00);
    en = 1'b1; s = 8'h10; r = 8'h00;
    cyc(1);
    check("lit_en1_q", 0, 32'(main_q[4]), 32'h1);
    check("lit_en1_err", 0, 32'(main_err), 32'h00);

    // counter: five event cycles on ch6
    s = 8'h40; r = 8'h40;
    cyc(7);
`ifdef SR_BANK_ERRCNT_EN
    check("lit_cnt_sat", 0, 32'(main_cnt), 32'h3);
`else
    check("lit_cnt_off", 0, 32'(main_cnt), 32'h0);
`endif
    s = 8'h00; r = 8'h00; err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("lit_cnt_clr", 0, 32'(main_cnt), 32'h0);

    // reset mid-operation discards filter progress on ch7
    s = 8'h80;
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    check("lit_async_q", 0, 32'(main_q), 32'h00);
    check("lit_async_qn", 0, 32'(main_qn), 32'hFF);
    check("lit_async_err", 0, 32'(main_err), 32'h00);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    check("lit_refilt_early", 0, 32'(main_q[7]), 32'h0);
    cyc(1);
    check("lit_refilt_edge3", 0, 32'(main_q[7]), 32'h1);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
